// File: rtl/ov5640_sccb_init_seq.sv
// OV5640 bring-up: walks a {addr16,data8} init table, one SCCB write per entry.
// Define OV5640_SEQ_ACK_CHECK_EN to abort the sequence on a NACKed ack slot.
module ov5640_sccb_init_seq #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned INIT_LEN   = 252,
  parameter logic [7:0]  DEVICE_ID  = 8'h78,
  parameter int unsigned CLK_DIV    = 125,
  parameter logic [19:0] PWR_DELAY  = 20'd240000,
  parameter logic [19:0] RST_DELAY  = 20'd120000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  sccb_scl,
  output logic                  sccb_sda_oe,
  input  logic                  sccb_sda_i,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_index
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);
  localparam logic [19:0] GAP_LAST = 20'(4 * CLK_DIV - 1);
  localparam logic [19:0] PWR_LAST = PWR_DELAY - 20'd1;
  localparam logic [19:0] RST_LAST = RST_DELAY - 20'd1;
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(INIT_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_FETCH, S_LATCH, S_WRITE,
    S_GAP, S_RST, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [QW-1:0] qdiv_q, qdiv_d;
  logic [1:0] qtr_q, qtr_d;
  logic [5:0] bit_q, bit_d;
  logic [35:0] frame_q, frame_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] eidx_q, eidx_d;
  logic srst_q, srst_d;
  logic nack_q, nack_d;
  logic scl_q, scl_d;
  logic oe_q, oe_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic q_end, data_bit, ack_slot;

  assign q_end = (qdiv_q == QLAST);
  assign data_bit = (bit_q != 6'd0) && (bit_q != 6'd37);
  assign ack_slot = (bit_q == 6'd9) || (bit_q == 6'd18) ||
                    (bit_q == 6'd27) || (bit_q == 6'd36);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qdiv_d  = qdiv_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    eidx_d  = eidx_q;
    srst_d  = srst_q;
    nack_d  = nack_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PWR;
          cnt_d   = '0;
          idx_d   = '0;
          eidx_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_PWR: begin
        if (cnt_q == PWR_LAST) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_WRITE;
        frame_d = {DEVICE_ID, 1'b1, rom_q[23:16], 1'b1,
                   rom_q[15:8], 1'b1, rom_q[7:0], 1'b1};
        srst_d  = (rom_q[23:8] == 16'h3008) && rom_q[7];
        nack_d  = 1'b0;
        qdiv_d  = '0;
        qtr_d   = '0;
        bit_d   = '0;
      end
      S_WRITE: begin
        qdiv_d = qdiv_q + 1'b1;
`ifdef OV5640_SEQ_ACK_CHECK_EN
        if (q_end && qtr_q == 2'd1 && ack_slot && sccb_sda_i)
          nack_d = 1'b1;
`endif
        if (q_end) begin
          qdiv_d = '0;
          qtr_d  = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            bit_d = bit_q + 6'd1;
            if (data_bit)
              frame_d = {frame_q[34:0], 1'b1};
            if (bit_q == 6'd37) begin
              state_d = nack_q ? S_ERR : S_GAP;
              cnt_d   = '0;
            end
          end
        end
      end
      S_GAP, S_RST: begin
        if ((state_q == S_GAP && cnt_q == GAP_LAST) ||
            (state_q == S_RST && cnt_q == RST_LAST)) begin
          cnt_d = '0;
          if (state_q == S_GAP && srst_q) begin
            state_d = S_RST;
          end else if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE)
      done_d = 1'b1;
    if (state_d == S_ERR) begin
      err_d  = 1'b1;
      eidx_d = idx_q;
    end
  end

  assign busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});

  // Bus levels per quarter; registered, so the pins trail the phase by a cycle.
  always_comb begin
    scl_d = 1'b1;
    oe_d  = 1'b0;
    if (state_q == S_WRITE) begin
      if (bit_q == 6'd0) begin
        scl_d = (qtr_q != 2'd3);
        oe_d  = (qtr_q != 2'd0);
      end else if (bit_q == 6'd37) begin
        scl_d = (qtr_q != 2'd0);
        oe_d  = (qtr_q < 2'd2);
      end else begin
        scl_d = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        oe_d  = ~frame_q[35];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      qdiv_q  <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      idx_q   <= '0;
      eidx_q  <= '0;
      srst_q  <= 1'b0;
      nack_q  <= 1'b0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qdiv_q  <= qdiv_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      eidx_q  <= eidx_d;
      srst_q  <= srst_d;
      nack_q  <= nack_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_addr    = idx_q;
  assign sccb_scl    = scl_q;
  assign sccb_sda_oe = oe_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef OV5640_SEQ_ACK_CHECK_EN
  assign error     = err_q;
  assign err_index = eidx_q;
`else
  assign error     = 1'b0;
  assign err_index = '0;
  wire unused_ack = ^{sccb_sda_i, err_q, eidx_q};
`endif

endmodule

// File: tb/tb_ov5640_sccb_init_seq.sv
// Scoreboard bench: expected SCCB bytes queued at start, popped by a bus monitor.
module tb_ov5640_sccb_init_seq;

  localparam int CD = 4;
  localparam int PWR = 10;
  localparam int RSTD = 50;
  localparam int ENTRY = 2 + 156 * CD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] rom_addr;
  logic [23:0] rom_q;
  logic sccb_scl, sccb_sda_oe, sccb_sda_i;
  logic busy, done, error;
  logic [7:0] err_index;

  logic [23:0] rom [0:255];
  logic slave_drive = 1'b0;
  logic scl_p = 1'b1;
  logic sda_p = 1'b1;
  logic sda_line;
  logic [7:0] shreg = '0;
  int cyc = 0;
  int bitcnt = 0;
  int frames = 0;
  int nack_frame = -1;
  int nack_byte = -1;
  int extra = 0;
  int start_cyc [0:63];
  int stop_cyc [0:63];
  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  ov5640_sccb_init_seq #(
    .DATA_WIDTH(24), .ADDR_WIDTH(8), .INIT_LEN(3),
    .DEVICE_ID(8'h78), .CLK_DIV(CD),
    .PWR_DELAY(20'(PWR)), .RST_DELAY(20'(RSTD))
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .sccb_scl(sccb_scl), .sccb_sda_oe(sccb_sda_oe),
    .sccb_sda_i(sccb_sda_i), .busy(busy), .done(done),
    .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= rom[rom_addr];

  assign sda_line = !sccb_sda_oe && !slave_drive;
  assign sccb_sda_i = sda_line;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic byte_rx(logic [7:0] b);
    if (sb.size() == 0) extra++;
    else check("byte", 32'(b), 32'(sb.pop_front()));
  endtask

  always @(negedge clk) begin
    scl_p <= sccb_scl;
    sda_p <= sda_line;
    if (!rst_n) begin
      bitcnt <= 0;
      slave_drive <= 1'b0;
    end else if (scl_p && sccb_scl && sda_p && !sda_line) begin
      start_cyc[frames] <= cyc;
      frames <= frames + 1;
      bitcnt <= 0;
    end else if (scl_p && sccb_scl && !sda_p && sda_line) begin
      if (frames > 0) stop_cyc[frames-1] <= cyc;
    end else if (!scl_p && sccb_scl) begin
      bitcnt <= bitcnt + 1;
      if (bitcnt % 9 < 8) shreg <= {shreg[6:0], sda_line};
      if (bitcnt % 9 == 7) byte_rx({shreg[6:0], sda_line});
    end else if (scl_p && !sccb_scl) begin
      slave_drive <= (bitcnt % 9 == 8) &&
        !((frames - 1 == nack_frame) && (bitcnt / 9 == nack_byte));
    end
  end

  task automatic load(logic [23:0] a, logic [23:0] b, logic [23:0] c);
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
  endtask

  task automatic push_seq();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'h78);
      sb.push_back(rom[i][23:16]);
      sb.push_back(rom[i][15:8]);
      sb.push_back(rom[i][7:0]);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output int el, input int t0);
    el = 0;
    for (int i = 0; i < 4000 && !(done || error); i++) @(negedge clk);
    check("end_seen", 32'(done || error), 1);
    el = cyc - t0;
  endtask

  initial begin
    int t0, el, base, g0, g1;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    load(24'h310311, 24'h430061, 24'h501f01);
    repeat (3) @(negedge clk);
    check("rst_scl", 32'(sccb_scl), 1);
    check("rst_oe", 32'(sccb_sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_eidx", 32'(err_index), 0);
    check("rst_addr", 32'(rom_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal run with a start pulse during frame 1
    base = frames;
    push_seq();
    pulse_start();
    t0 = cyc;
    check("busy_rise", 32'(busy), 1);
    for (int i = 0; i < 2000 && frames - base < 2; i++) @(negedge clk);
    check("frame1_seen", 32'(frames - base), 2);
    pulse_start();
    wait_end(el, t0);
    check("done_cyc", 32'(el >= PWR + 3 * ENTRY - 1 && el <= PWR + 3 * ENTRY + 1), 1);
    check("done1", 32'(done), 1);
    check("err1", 32'(error), 0);
    check("frames1", 32'(frames - base), 3);
    check("sb1", 32'(sb.size()), 0);
    // start on the DONE cycle is ignored
    pulse_start();
    check("start_in_done", 32'(busy), 0);
    check("done_sticky", 32'(done), 1);
    @(negedge clk);

    // Replay clears done and restarts from index 0
    base = frames;
    push_seq();
    pulse_start();
    t0 = cyc;
    check("replay_done_clr", 32'(done), 0);
    check("replay_busy", 32'(busy), 1);
    wait_end(el, t0);
    check("done2", 32'(done), 1);
    check("sb2", 32'(sb.size()), 0);
    repeat (2) @(negedge clk);

    // Soft reset only for 3008 with data bit 7 set
    load(24'h300842, 24'h300882, 24'h501f01);
    base = frames;
    push_seq();
    pulse_start();
    t0 = cyc;
    wait_end(el, t0);
    g0 = start_cyc[base+1] - stop_cyc[base];
    g1 = start_cyc[base+2] - stop_cyc[base+1];
    check("rst_gap_delta", 32'(g1 - g0), RSTD);
    check("srst_total", 32'(el >= PWR + 3 * ENTRY + RSTD - 1 &&
                            el <= PWR + 3 * ENTRY + RSTD + 1), 1);
    check("sb3", 32'(sb.size()), 0);
    repeat (2) @(negedge clk);

    // Slave NACKs address-low byte of index 2
    load(24'h310311, 24'h430061, 24'h501f01);
    base = frames;
    nack_frame = base + 2;
    nack_byte = 2;
    push_seq();
    pulse_start();
    t0 = cyc;
    wait_end(el, t0);
`ifdef OV5640_SEQ_ACK_CHECK_EN
    check("nack_error", 32'(error), 1);
    check("nack_eidx", 32'(err_index), 2);
    check("nack_done", 32'(done), 0);
`else
    check("nack_done", 32'(done), 1);
    check("nack_error", 32'(error), 0);
`endif
    repeat (200) @(negedge clk);
    check("nack_frames", 32'(frames - base), 3);
    check("nack_bus_idle", 32'(sccb_scl && !sccb_sda_oe), 1);
    check("sb4", 32'(sb.size()), 0);
    nack_frame = -1;
    nack_byte = -1;

    // Reset in the middle of frame 0
    base = frames;
    push_seq();
    pulse_start();
    for (int i = 0; i < 2000 && !(frames - base == 1 && bitcnt >= 20); i++)
      @(negedge clk);
    check("mid_bit20", 32'(bitcnt), 20);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_scl", 32'(sccb_scl), 1);
    check("mid_oe", 32'(sccb_sda_oe), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_addr", 32'(rom_addr), 0);
    sb.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = frames;
    push_seq();
    pulse_start();
    t0 = cyc;
    wait_end(el, t0);
    check("mid_done", 32'(done), 1);
    check("mid_frames", 32'(frames - base), 3);
    check("sb5", 32'(sb.size()), 0);
    check("extra_bytes", 32'(extra), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
